sp_sram_bank_gen: RTL and testbench
===================================

SP_SRAM_BANK_GEN -- requirements
Module: sp_sram_bank_gen

Interface
REQ-001 SHALL have parameter DW, default 128: total bank data width in bits; multiple of 8*NUM_SUB.
REQ-002 SHALL have parameter AW, default 11: row address width per sub-macro (depth 2**AW).
REQ-003 SHALL have parameter NUM_SUB, default 4: number of sub-macros (lanes), power of two >= 2; lane width SW = DW/NUM_SUB.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds a read-data output register stage.
REQ-005 SHALL have parameter INIT_ZERO, default 1: 1 zero-fills all rows after reset.
REQ-006 SHALL use one clock; reset is asynchronous and active-high. Ports: clk in 1, the clock; rst_i in 1, the reset.
REQ-007 req_i in 1: access request, held until granted.
REQ-008 gnt_o out 1: request accepted this cycle.
REQ-009 addr_i in AW+log2(NUM_SUB): {row, lane sel}; sel = LSBs.
REQ-010 we_i in 1: 1 write, 0 read.
REQ-011 be_i in DW/8: byte enables, active-high.
REQ-012 wdata_i in DW: write data.
REQ-013 narrow_access_i in 1: 1 = single-lane (SW-bit) access.
REQ-014 ram_ctrl_i in 6: macro timing trims, passed unchanged to every lane.
REQ-015 rvalid_o out 1: rdata_o valid, one-cycle pulse per granted read.
REQ-016 rdata_o out DW: read data.
REQ-017 init_done_o out 1: high once zero-fill is complete (or immediately after reset when INIT_ZERO=0).

Function
REQ-018 FSM states SHALL be INIT and READY; reset enters INIT if INIT_ZERO=1, else READY.
REQ-019 In INIT, a row counter SHALL write all-zero, all-bytes-enabled to row 0..2**AW-1 of every lane, one row per cycle; on the cycle that writes the last row it SHALL move to READY (no wrap).
REQ-020 gnt_o SHALL equal req_i AND (state == READY), combinationally; gnt_o SHALL be 0 in INIT.
REQ-021 Wide access (narrow_access_i=0): all lanes enabled; lane i uses wdata_i[i*SW +: SW] and be_i[i*SW/8 +: SW/8].
REQ-022 Narrow access: only lane sel enabled; it uses wdata_i[SW-1:0] and be_i[SW/8-1:0].
REQ-023 Lane write byte-mask SHALL be active only when be_i bit and we_i are both 1; a write with be_i all-zero SHALL leave the memory unchanged.
REQ-024 Read latency from grant to rvalid_o SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); back-to-back reads every cycle SHALL be supported with one rvalid_o pulse each.
REQ-025 Wide read SHALL return {lane NUM_SUB-1, ..., lane 0}; narrow read SHALL return the selected lane right-aligned, upper DW-SW bits zero.
REQ-026 sel and narrow_access_i SHALL be pipelined alongside the read so muxing uses the values captured at grant.
REQ-027 rdata_o SHALL hold its last value when rvalid_o is 0; writes SHALL not assert rvalid_o.
REQ-028 Read of a row written in the immediately preceding cycle SHALL return the new data.

Reset
REQ-029 On rst_i: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0 (1 if INIT_ZERO=0), row counter=0, pipeline valids cleared.
REQ-030 Reset asserted mid-INIT or mid-read SHALL restart INIT from row 0 and drop any in-flight read without an rvalid_o pulse.

Structure
REQ-031 Package sp_sram_bank_pkg SHALL hold the state typedef (INIT, READY) and the lane-width/select-width helper constants.
REQ-032 One sub-module sp_sram_lane SHALL model a single SW x 2**AW synchronous single-port lane (1-cycle read, active-low enable/byte mask), instantiated NUM_SUB times.

Verification
REQ-033 Reset release, INIT_ZERO=1, defaults -> gnt_o=0 and init_done_o=0 for 2048 cycles, then init_done_o=1; wide read of row 5 returns 0.
REQ-034 Wide write row 3 data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, be all 1 -> wide read returns same value 1 cycle after grant.
REQ-035 Narrow write addr {row 3, sel 2} data 32'hDEADBEEF, be 4'b0011 -> wide read row 3 lane 2 = 32'h7654BEEF; narrow read sel 2 returns {96'b0, 32'h7654BEEF}.
REQ-036 Reads granted on 4 consecutive cycles with OUT_REG=1 -> 4 consecutive rvalid_o pulses starting 2 cycles after first grant, data in request order.
REQ-037 req_i high during INIT -> no grant until READY; grant asserted the first READY cycle.
REQ-038 rst_i pulsed at INIT row 1000 -> init_done_o stays 0, INIT restarts at row 0, completes 2048 cycles after release.

Source files
------------

// File: rtl/sp_sram_bank_pkg.sv
// rtl/sp_sram_bank_pkg.sv - shared state encoding and lane geometry helpers for the SRAM bank
package sp_sram_bank_pkg;

  typedef logic [0:0] state_t;

  localparam state_t INIT  = 1'b0;
  localparam state_t READY = 1'b1;

  function automatic int lane_width(input int dw, input int num_sub);
    return dw / num_sub;
  endfunction

  function automatic int sel_width(input int num_sub);
    return (num_sub > 1) ? $clog2(num_sub) : 1;
  endfunction

endpackage

// File: rtl/sp_sram_lane.sv
// rtl/sp_sram_lane.sv - one SW x 2**AW synchronous single-port lane, active-low enable and byte mask
module sp_sram_lane #(
  parameter int SW = 32,
  parameter int AW = 11
) (
  input  logic            clk,
  input  logic            cen_n_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [SW/8-1:0] bm_n_i,
  input  logic [SW-1:0]   d_i,
  input  logic [5:0]      ram_ctrl_i,
  output logic [SW-1:0]   q_o
);

  logic [SW-1:0] mem_q [2**AW];
  logic [SW-1:0] q_q;

  // Timing trims only matter to a real macro; the behavioural lane ignores them.
  logic unused_ram_ctrl;
  assign unused_ram_ctrl = ^ram_ctrl_i;

  always_ff @(posedge clk) begin
    if (!cen_n_i) begin
      q_q <= mem_q[addr_i];
      for (int b = 0; b < SW/8; b++) begin
        if (!bm_n_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
        end
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sp_sram_bank_gen.sv
// rtl/sp_sram_bank_gen.sv - banked single-port SRAM: NUM_SUB lanes, wide/narrow access, optional zero-fill
module sp_sram_bank_gen
  import sp_sram_bank_pkg::*;
#(
  parameter int DW        = 128,
  parameter int AW        = 11,
  parameter int NUM_SUB   = 4,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic [AW+$clog2(NUM_SUB)-1:0] addr_i,
  input  logic                          we_i,
  input  logic [DW/8-1:0]               be_i,
  input  logic [DW-1:0]                 wdata_i,
  input  logic                          narrow_access_i,
  input  logic [5:0]                    ram_ctrl_i,
  output logic                          rvalid_o,
  output logic [DW-1:0]                 rdata_o,
  output logic                          init_done_o
);

  localparam int SW   = lane_width(DW, NUM_SUB);
  localparam int SELW = sel_width(NUM_SUB);
  localparam int BW   = SW / 8;

  state_t state_q, state_d;
  logic [AW-1:0] row_q, row_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q == INIT) begin
      row_d = row_q + 1'b1;
      if (row_q == {AW{1'b1}}) state_d = READY;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (INIT_ZERO != 0) ? INIT : READY;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  assign gnt_o       = req_i && (state_q == READY);
  assign init_done_o = (state_q == READY);

  logic [AW-1:0]   req_row;
  logic [SELW-1:0] req_sel;
  assign req_row = addr_i[AW+SELW-1:SELW];
  assign req_sel = addr_i[SELW-1:0];

  logic            lane_cen_n [NUM_SUB];
  logic [AW-1:0]   lane_addr  [NUM_SUB];
  logic [BW-1:0]   lane_bm_n  [NUM_SUB];
  logic [SW-1:0]   lane_d     [NUM_SUB];
  logic [SW-1:0]   lane_q     [NUM_SUB];

  // Zero-fill owns every lane in INIT; afterwards lanes follow the granted request.
  always_comb begin
    for (int i = 0; i < NUM_SUB; i++) begin
      lane_cen_n[i] = 1'b1;
      lane_addr[i]  = req_row;
      lane_bm_n[i]  = '1;
      lane_d[i]     = '0;
      if (state_q == INIT) begin
        lane_cen_n[i] = 1'b0;
        lane_addr[i]  = row_q;
        lane_bm_n[i]  = '0;
      end else begin
        lane_cen_n[i] = !(gnt_o && (!narrow_access_i || (req_sel == SELW'(i))));
        lane_d[i]     = narrow_access_i ? wdata_i[SW-1:0] : wdata_i[i*SW +: SW];
        lane_bm_n[i]  = ~((narrow_access_i ? be_i[BW-1:0] : be_i[i*BW +: BW]) & {BW{we_i}});
      end
    end
  end

  for (genvar g = 0; g < NUM_SUB; g++) begin : g_lane
    sp_sram_lane #(.SW(SW), .AW(AW)) u_lane (
      .clk        (clk),
      .cen_n_i    (lane_cen_n[g]),
      .addr_i     (lane_addr[g]),
      .bm_n_i     (lane_bm_n[g]),
      .d_i        (lane_d[g]),
      .ram_ctrl_i (ram_ctrl_i),
      .q_o        (lane_q[g])
    );
  end

  logic            rd_v1_q, rd_v1_d;
  logic [SELW-1:0] sel1_q, sel1_d;
  logic            narrow1_q, narrow1_d;

  always_comb begin
    rd_v1_d   = gnt_o && !we_i;
    sel1_d    = rd_v1_d ? req_sel : sel1_q;
    narrow1_d = rd_v1_d ? narrow_access_i : narrow1_q;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rd_v1_q   <= 1'b0;
      sel1_q    <= '0;
      narrow1_q <= 1'b0;
    end else begin
      rd_v1_q   <= rd_v1_d;
      sel1_q    <= sel1_d;
      narrow1_q <= narrow1_d;
    end
  end

  logic [DW-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (narrow1_q) begin
      rd_mux[SW-1:0] = lane_q[sel1_q];
    end else begin
      for (int i = 0; i < NUM_SUB; i++) rd_mux[i*SW +: SW] = lane_q[i];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
      rvalid_d = rd_v1_q;
      rdata_d  = rd_v1_q ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        rdata_q  <= rdata_d;
      end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
  end else begin : g_ocomb
    // Lane outputs move on writes too, so the last returned word is kept separately.
    logic [DW-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = rd_v1_q ? rd_mux : hold_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) hold_q <= '0;
      else       hold_q <= hold_d;
    end

    assign rvalid_o = rd_v1_q;
    assign rdata_o  = rd_v1_q ? rd_mux : hold_q;
  end

endmodule

// File: tb/tb_sp_sram_bank_gen.sv
// tb/tb_sp_sram_bank_gen.sv - directed bench for sp_sram_bank_gen, combinational and registered read paths
module tb_sp_sram_bank_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [12:0]  addr;
  logic         we;
  logic [15:0]  be;
  logic [127:0] wdata;
  logic         narrow;
  logic [5:0]   ram_ctrl = 6'h2A;

  logic         gnt0, rv0, done0;
  logic [127:0] rd0;
  logic         gnt1, rv1, done1;
  logic [127:0] rd1;

  int total = 0;
  int bad   = 0;
  int errs;

  localparam logic [127:0] C = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] E = 128'h0123_4567_7654_BEEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  sp_sram_bank_gen #(.OUT_REG(0)) dut0 (
    .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .narrow_access_i(narrow), .ram_ctrl_i(ram_ctrl),
    .rvalid_o(rv0), .rdata_o(rd0), .init_done_o(done0)
  );

  sp_sram_bank_gen #(.OUT_REG(1)) dut1 (
    .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .narrow_access_i(narrow), .ram_ctrl_i(ram_ctrl),
    .rvalid_o(rv1), .rdata_o(rd1), .init_done_o(done1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] mk(input int row, input int sel);
    return {row[10:0], sel[1:0]};
  endfunction

  task automatic set_in(input logic r, input logic w, input logic n, input logic [12:0] a,
                        input logic [15:0] b, input logic [127:0] d);
    req = r; we = w; narrow = n; addr = a; be = b; wdata = d;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 13'd0, 16'h0, 128'h0);
  endtask

  task automatic count_init();
    errs = 0;
    for (int k = 0; k < 2048; k++) begin
      if (done0 !== 1'b0 || done1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) errs++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) step();

    set_in(1'b1, 1'b0, 1'b0, mk(5, 0), 16'hFFFF, 128'h0);
    #1;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_rv0", rv0, 1'b0);
    chk("rst_rv1", rv1, 1'b0);
    chk("rst_rd0", rd0, 128'h0);
    chk("rst_rd1", rd1, 128'h0);
    chk("rst_done0", done0, 1'b0);

    rst = 1'b0;
    count_init();
    chk("init_quiet", errs, 0);
    chk("init_done0", done0, 1'b1);
    chk("init_done1", done1, 1'b1);
    chk("first_ready_gnt", gnt0, 1'b1);

    step();
    chk("row5_rv0", rv0, 1'b1);
    chk("row5_rd0", rd0, 128'h0);
    chk("row5_rv1_early", rv1, 1'b0);
    idle();
    step();
    chk("row5_rv0_end", rv0, 1'b0);
    chk("row5_rv1", rv1, 1'b1);
    chk("row5_rd1", rd1, 128'h0);

    set_in(1'b1, 1'b1, 1'b0, mk(3, 0), 16'hFFFF, C);
    #1;
    chk("wr_gnt", gnt0, 1'b1);
    step();
    chk("wr_no_rv0", rv0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, mk(3, 0), 16'hFFFF, 128'h0);
    step();
    chk("wide_rv0", rv0, 1'b1);
    chk("wide_rd0", rd0, C);
    idle();
    step();
    chk("wide_rv0_end", rv0, 1'b0);
    chk("wide_hold0", rd0, C);
    chk("wide_rv1", rv1, 1'b1);
    chk("wide_rd1", rd1, C);

    set_in(1'b1, 1'b1, 1'b1, mk(3, 2), 16'hFFFF, {96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'h7654_3210});
    step();
    set_in(1'b1, 1'b1, 1'b1, mk(3, 2), 16'hFFF3, {96'h5555_5555_5555_5555_5555_5555, 32'hDEAD_BEEF});
    step();
    set_in(1'b1, 1'b1, 1'b0, mk(3, 0), 16'h0000, {128{1'b1}});
    step();
    chk("nwr_no_rv1", rv1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, mk(3, 0), 16'h0, 128'h0);
    step();
    chk("narrow_wide_rd0", rd0, E);
    set_in(1'b1, 1'b0, 1'b1, mk(3, 2), 16'h0, 128'h0);
    step();
    chk("narrow_rd0", rd0, {96'h0, 32'h7654_BEEF});
    idle();
    step();

    set_in(1'b1, 1'b0, 1'b0, mk(3, 0), 16'h0, 128'h0);
    #1;
    chk("b2b_gnt1", gnt1, 1'b1);
    step();
    chk("b2b_a_rv0", rv0, 1'b1);
    chk("b2b_a_rd0", rd0, E);
    chk("b2b_lat_rv1", rv1, 1'b0);
    set_in(1'b1, 1'b0, 1'b1, mk(3, 2), 16'h0, 128'h0);
    step();
    chk("b2b_b_rd0", rd0, {96'h0, 32'h7654_BEEF});
    chk("b2b_a_rv1", rv1, 1'b1);
    chk("b2b_a_rd1", rd1, E);
    set_in(1'b1, 1'b0, 1'b1, mk(3, 1), 16'h0, 128'h0);
    step();
    chk("b2b_b_rv1", rv1, 1'b1);
    chk("b2b_b_rd1", rd1, {96'h0, 32'h7654_BEEF});
    set_in(1'b1, 1'b0, 1'b1, mk(3, 3), 16'h0, 128'h0);
    step();
    chk("b2b_c_rv1", rv1, 1'b1);
    chk("b2b_c_rd1", rd1, {96'h0, 32'hFEDC_BA98});
    idle();
    step();
    chk("b2b_d_rv0_end", rv0, 1'b0);
    chk("b2b_d_rv1", rv1, 1'b1);
    chk("b2b_d_rd1", rd1, {96'h0, 32'h0123_4567});
    step();
    chk("b2b_rv1_end", rv1, 1'b0);
    chk("b2b_hold1", rd1, {96'h0, 32'h0123_4567});

    set_in(1'b1, 1'b0, 1'b0, mk(3, 0), 16'h0, 128'h0);
    step();
    rst = 1'b1;
    idle();
    #1;
    chk("midrd_rv0", rv0, 1'b0);
    chk("midrd_rd0", rd0, 128'h0);
    chk("midrd_rv1", rv1, 1'b0);
    chk("midrd_rd1", rd1, 128'h0);
    chk("midrd_done0", done0, 1'b0);
    step();
    step();
    chk("midrd_drop_rv1", rv1, 1'b0);

    rst = 1'b0;
    repeat (1000) step();
    chk("row1000_done0", done0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_init();
    chk("reinit_quiet", errs, 0);
    chk("reinit_done0", done0, 1'b1);

    set_in(1'b1, 1'b0, 1'b0, mk(3, 0), 16'h0, 128'h0);
    step();
    chk("refill_rv0", rv0, 1'b1);
    chk("refill_rd0", rd0, 128'h0);
    idle();
    step();
    chk("refill_rd1", rd1, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
